// File: rtl/id_pkg.sv
// id_pkg: shared types, default constants and helpers for the decode/operand stage
package id_pkg;
  localparam int REGI_BITS_DEF = 4;
  localparam int CNT_W_DEF = 2;
  localparam int PC_REG = 2**REGI_BITS_DEF - 1;
  localparam int CNT_MAX = 2**CNT_W_DEF - 1;
  typedef logic [31:0] ctrl_t;
  typedef logic [CNT_W_DEF-1:0] cnt_t;
  function automatic int all_ones(input int bits);
    return (1 << bits) - 1;
  endfunction
endpackage

// File: rtl/sb_counter_bank.sv
// sb_counter_bank: array of up/down in-flight writer counters with busy flags
module sb_counter_bank
  import id_pkg::*;
#(
  parameter int A_BITS = 4,
  parameter int CNT_W = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             inc,
  input  logic [A_BITS-1:0]                inc_addr,
  input  logic                             dec,
  input  logic [A_BITS-1:0]                dec_addr,
  output logic [2**A_BITS-1:0][CNT_W-1:0]  cnt,
  output logic [2**A_BITS-1:0]             busy
);
  localparam int N = 2**A_BITS;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0] inc_e, dec_e;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inc_e[i] = inc && inc_addr == A_BITS'(i);
      dec_e[i] = dec && dec_addr == A_BITS'(i);
      cnt_d[i] = (inc_e[i] && !dec_e[i]) ? cnt_q[i] + 1'b1 :
                 (dec_e[i] && !inc_e[i] && cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : cnt_q[i];
      busy[i] = |cnt_q[i];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/id_stage_sb.sv
// id_stage_sb: decode/operand stage with regfiles, scoreboard hazard stall and ID/EX register
module id_stage_sb
  import id_pkg::*;
#(
  parameter int REGI_BITS = 4,
  parameter int VECT_BITS = 2,
  parameter int REGI_SIZE = 16,
  parameter int VECT_SIZE = 8,
  parameter int ELEM_SIZE = 8,
  parameter int CNT_W = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [REGI_BITS-1:0]           i_src1,
  input  logic [REGI_BITS-1:0]           i_src2,
  input  logic [VECT_BITS-1:0]           v_src1,
  input  logic [VECT_BITS-1:0]           v_src2,
  input  logic [REGI_BITS-1:0]           i_dst,
  input  logic [VECT_BITS-1:0]           v_dst,
  input  logic                           use_i1,
  input  logic                           use_i2,
  input  logic                           use_v1,
  input  logic                           use_v2,
  input  logic                           wr_i,
  input  logic                           wr_v,
  input  logic [7:0]                     imm,
  input  ctrl_t                          ctrl_i,
  input  logic [REGI_SIZE-1:0]           next_pc,
  input  logic [1:0]                     alu_flags_i,
  input  logic                           wb_i_we,
  input  logic                           wb_v_we,
  input  logic [REGI_BITS-1:0]           wb_i_dst,
  input  logic [VECT_BITS-1:0]           wb_v_dst,
  input  logic [REGI_SIZE-1:0]           wb_i_data,
  input  logic [ELEM_SIZE*VECT_SIZE-1:0] wb_v_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [REGI_SIZE-1:0]           i_op1,
  output logic [REGI_SIZE-1:0]           i_op2,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] v_op1,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] v_op2,
  output logic [ELEM_SIZE*VECT_SIZE-1:0] v_imm,
  output logic [REGI_BITS-1:0]           o_i_dst,
  output logic [VECT_BITS-1:0]           o_v_dst,
  output logic                           o_wr_i,
  output logic                           o_wr_v,
  output ctrl_t                          ctrl_o,
  output logic [1:0]                     alu_flags_o
);
  localparam int NI = 2**REGI_BITS;
  localparam int NV = 2**VECT_BITS;
  localparam int VW = ELEM_SIZE*VECT_SIZE;
  localparam int PW = 2*REGI_SIZE + 3*VW + REGI_BITS + VECT_BITS + 2 + 32 + 2;
  localparam logic [REGI_BITS-1:0] PC = REGI_BITS'(all_ones(REGI_BITS));
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(all_ones(CNT_W));
  logic [NI-1:0][REGI_SIZE-1:0] rf_i_q, rf_i_d;
  logic [NV-1:0][VW-1:0] rf_v_q, rf_v_d;
  logic [PW-1:0] pl_q, pl_d;
  logic valid_q, valid_d;
  logic [NI-1:0][CNT_W-1:0] cnt_i;
  logic [NV-1:0][CNT_W-1:0] cnt_v;
  logic [NI-1:0] busy_i;
  logic [NV-1:0] busy_v;
  logic [REGI_SIZE-1:0] ri1, ri2;
  logic [VW-1:0] rv1, rv2;
  logic hazard, issue, capture;
  function automatic logic src_haz(input logic busy, input logic [CNT_W-1:0] cnt,
                                   input logic wb_hit, input logic out_hit);
    return (busy && !(cnt == CNT_W'(1) && wb_hit)) || out_hit;
  endfunction
  function automatic logic waw_haz(input logic [CNT_W-1:0] cnt, input logic out_hit);
    return cnt == CMAX || (out_hit && cnt == CMAX - 1'b1);
  endfunction
  assign ri1 = i_src1 == PC ? next_pc : (wb_i_we && wb_i_dst == i_src1) ? wb_i_data : rf_i_q[i_src1];
  assign ri2 = i_src2 == PC ? next_pc : (wb_i_we && wb_i_dst == i_src2) ? wb_i_data : rf_i_q[i_src2];
  assign rv1 = (wb_v_we && wb_v_dst == v_src1) ? wb_v_data : rf_v_q[v_src1];
  assign rv2 = (wb_v_we && wb_v_dst == v_src2) ? wb_v_data : rf_v_q[v_src2];
  // out_hit terms cover a writer captured last cycle that the scoreboard has not counted yet
  assign hazard =
      (use_i1 && src_haz(busy_i[i_src1], cnt_i[i_src1], wb_i_we && wb_i_dst == i_src1,
                         valid_q && o_wr_i && o_i_dst == i_src1)) ||
      (use_i2 && src_haz(busy_i[i_src2], cnt_i[i_src2], wb_i_we && wb_i_dst == i_src2,
                         valid_q && o_wr_i && o_i_dst == i_src2)) ||
      (use_v1 && src_haz(busy_v[v_src1], cnt_v[v_src1], wb_v_we && wb_v_dst == v_src1,
                         valid_q && o_wr_v && o_v_dst == v_src1)) ||
      (use_v2 && src_haz(busy_v[v_src2], cnt_v[v_src2], wb_v_we && wb_v_dst == v_src2,
                         valid_q && o_wr_v && o_v_dst == v_src2)) ||
      (wr_i && waw_haz(cnt_i[i_dst], valid_q && o_wr_i && o_i_dst == i_dst)) ||
      (wr_v && waw_haz(cnt_v[v_dst], valid_q && o_wr_v && o_v_dst == v_dst));
  assign in_ready = !rst && !hazard && (!valid_q || out_ready);
  assign out_valid = valid_q && !flush;
  assign issue = out_valid && out_ready;
  assign capture = in_valid && in_ready && !flush;
  always_comb begin
    rf_i_d = rf_i_q;
    rf_v_d = rf_v_q;
    if (wb_i_we && wb_i_dst != PC) rf_i_d[wb_i_dst] = wb_i_data;
    if (wb_v_we) rf_v_d[wb_v_dst] = wb_v_data;
    valid_d = flush ? 1'b0 : capture ? 1'b1 : issue ? 1'b0 : valid_q;
    pl_d = capture ? {ri1, ri2, rv1, rv2, {VECT_SIZE{ELEM_SIZE'(imm)}}, i_dst, v_dst,
                      wr_i, wr_v, ctrl_i, alu_flags_i} : pl_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rf_i_q <= '0;
      rf_v_q <= '0;
      valid_q <= 1'b0;
      pl_q <= '0;
    end else begin
      rf_i_q <= rf_i_d;
      rf_v_q <= rf_v_d;
      valid_q <= valid_d;
      pl_q <= pl_d;
    end
  assign {i_op1, i_op2, v_op1, v_op2, v_imm, o_i_dst, o_v_dst, o_wr_i, o_wr_v, ctrl_o, alu_flags_o} = pl_q;
  sb_counter_bank #(.A_BITS(REGI_BITS), .CNT_W(CNT_W)) u_sb_i (
    .clk(clk), .rst(rst), .inc(issue && o_wr_i), .inc_addr(o_i_dst),
    .dec(wb_i_we), .dec_addr(wb_i_dst), .cnt(cnt_i), .busy(busy_i)
  );
  sb_counter_bank #(.A_BITS(VECT_BITS), .CNT_W(CNT_W)) u_sb_v (
    .clk(clk), .rst(rst), .inc(issue && o_wr_v), .inc_addr(o_v_dst),
    .dec(wb_v_we), .dec_addr(wb_v_dst), .cnt(cnt_v), .busy(busy_v)
  );
endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: directed vectors with hand-computed expectations for id_stage_sb
module tb_id_stage_sb;
  logic clk = 0, rst;
  logic in_valid, in_ready;
  logic [3:0] i_src1, i_src2, i_dst, wb_i_dst, o_i_dst;
  logic [1:0] v_src1, v_src2, v_dst, wb_v_dst, o_v_dst;
  logic use_i1, use_i2, use_v1, use_v2, wr_i, wr_v, o_wr_i, o_wr_v;
  logic [7:0] imm;
  logic [31:0] ctrl_i, ctrl_o;
  logic [15:0] next_pc, wb_i_data, i_op1, i_op2;
  logic [1:0] alu_flags_i, alu_flags_o;
  logic wb_i_we, wb_v_we, flush, out_valid, out_ready;
  logic [63:0] wb_v_data, v_op1, v_op2, v_imm;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  id_stage_sb u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i_src1(i_src1), .i_src2(i_src2), .v_src1(v_src1), .v_src2(v_src2),
    .i_dst(i_dst), .v_dst(v_dst), .use_i1(use_i1), .use_i2(use_i2),
    .use_v1(use_v1), .use_v2(use_v2), .wr_i(wr_i), .wr_v(wr_v), .imm(imm),
    .ctrl_i(ctrl_i), .next_pc(next_pc), .alu_flags_i(alu_flags_i),
    .wb_i_we(wb_i_we), .wb_v_we(wb_v_we), .wb_i_dst(wb_i_dst), .wb_v_dst(wb_v_dst),
    .wb_i_data(wb_i_data), .wb_v_data(wb_v_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .i_op1(i_op1), .i_op2(i_op2),
    .v_op1(v_op1), .v_op2(v_op2), .v_imm(v_imm), .o_i_dst(o_i_dst), .o_v_dst(o_v_dst),
    .o_wr_i(o_wr_i), .o_wr_v(o_wr_v), .ctrl_o(ctrl_o), .alu_flags_o(alu_flags_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic [3:0] s1, s2, input logic u1, u2, input logic [3:0] d, input logic w);
    i_src1 = s1; i_src2 = s2; use_i1 = u1; use_i2 = u2; i_dst = d; wr_i = w;
    use_v1 = 0; use_v2 = 0; wr_v = 0;
  endtask
  task automatic wb(input logic [3:0] d, input logic [15:0] x);
    wb_i_we = 1; wb_i_dst = d; wb_i_data = x;
  endtask
  function automatic logic [63:0] ci(input int r);
    return 64'(u_dut.cnt_i[r]);
  endfunction
  initial begin
    rst = 1; in_valid = 0; out_ready = 1; flush = 0;
    ins(0, 0, 0, 0, 0, 0);
    v_src1 = 0; v_src2 = 0; v_dst = 0; imm = 0; ctrl_i = 0; next_pc = 0; alu_flags_i = 0;
    wb_i_we = 0; wb_v_we = 0; wb_i_dst = 0; wb_v_dst = 0; wb_i_data = 0; wb_v_data = 0;
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    rst = 0; #1;
    check("idle_in_ready", in_ready, 1);
    ins(0, 0, 0, 0, 1, 1); in_valid = 1; #1;
    check("b2b_rdy0", in_ready, 1);
    step();
    check("b2b_valid0", out_valid, 1);
    check("b2b_dst0", o_i_dst, 1);
    ins(0, 0, 0, 0, 2, 1); #1;
    check("b2b_rdy1", in_ready, 1);
    step();
    check("b2b_valid1", out_valid, 1);
    check("b2b_dst1", o_i_dst, 2);
    check("b2b_cnt1_a", ci(1), 1);
    in_valid = 0;
    step();
    check("b2b_drain", out_valid, 0);
    check("b2b_cnt1", ci(1), 1);
    check("b2b_cnt2", ci(2), 1);
    wb(1, 16'h1111); step();
    wb(2, 16'h2222); step();
    wb_i_we = 0;
    check("wb_cnt1", ci(1), 0);
    check("wb_cnt2", ci(2), 0);
    ins(1, 2, 1, 1, 0, 0); in_valid = 1;
    step();
    check("rd_op1", i_op1, 16'h1111);
    check("rd_op2", i_op2, 16'h2222);
    ins(0, 0, 0, 0, 5, 1);
    step();
    ins(5, 0, 1, 0, 0, 0); #1;
    check("raw_outreg_stall", in_ready, 0);
    step();
    check("raw_cnt5", ci(5), 1);
    check("raw_stall1", in_ready, 0);
    step();
    check("raw_stall2", in_ready, 0);
    wb(5, 16'hBEEF); #1;
    check("raw_bypass_rdy", in_ready, 1);
    step();
    wb_i_we = 0; in_valid = 0;
    check("raw_valid", out_valid, 1);
    check("raw_op1", i_op1, 16'hBEEF);
    check("raw_cnt5_clr", ci(5), 0);
    ins(0, 0, 0, 0, 3, 1); imm = 8'h3C; in_valid = 1;
    step();
    out_ready = 0;
    ins(0, 0, 0, 0, 4, 1); imm = 8'h11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_dst", o_i_dst, 3);
      check("bp_imm", v_imm, 64'h3C3C3C3C3C3C3C3C);
      check("bp_rdy", in_ready, 0);
      check("bp_cnt3", ci(3), 0);
      step();
    end
    out_ready = 1; #1;
    check("bp_release_rdy", in_ready, 1);
    step();
    check("bp_next_valid", out_valid, 1);
    check("bp_next_dst", o_i_dst, 4);
    check("bp_cnt3_inc", ci(3), 1);
    in_valid = 0;
    step();
    check("bp_drain", out_valid, 0);
    check("bp_cnt4", ci(4), 1);
    wb(3, 0); step();
    wb(4, 0); step();
    wb_i_we = 0;
    ins(0, 0, 0, 0, 0, 0); wr_v = 1; v_dst = 2; in_valid = 1;
    step();
    check("fl_valid_pre", out_valid, 1);
    ins(0, 0, 0, 0, 7, 1); flush = 1; #1;
    check("fl_valid_now", out_valid, 0);
    step();
    flush = 0; in_valid = 0;
    check("fl_valid_after", out_valid, 0);
    check("fl_cnt_v2", 64'(u_dut.cnt_v[2]), 0);
    check("fl_cnt_i7", ci(7), 0);
    ins(15, 0, 1, 0, 0, 0); next_pc = 16'h0040; imm = 8'hA5;
    v_src1 = 1; use_v1 = 1;
    wb_v_we = 1; wb_v_dst = 1; wb_v_data = 64'h0102030405060708;
    ctrl_i = 32'hDEADBEEF; alu_flags_i = 2'b10; in_valid = 1;
    step();
    wb_v_we = 0; in_valid = 0;
    check("pc_op1", i_op1, 16'h0040);
    check("imm_bcast", v_imm, 64'hA5A5A5A5A5A5A5A5);
    check("vbypass_op1", v_op1, 64'h0102030405060708);
    check("ctrl_pass", ctrl_o, 32'hDEADBEEF);
    check("flags_pass", alu_flags_o, 2'b10);
    step();
    ins(0, 0, 0, 0, 3, 1); in_valid = 1;
    step();
    step();
    ins(0, 0, 0, 0, 6, 1);
    step();
    in_valid = 0;
    check("pre_rst_cnt3", ci(3), 2);
    check("pre_rst_valid", out_valid, 1);
    rst = 1;
    step();
    check("mrst_valid", out_valid, 0);
    check("mrst_cnt3", ci(3), 0);
    check("mrst_op1", i_op1, 0);
    check("mrst_imm", v_imm, 0);
    check("mrst_in_ready", in_ready, 0);
    rst = 0;
    step();
    check("mrst_cnt6", ci(6), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
- Parametrised next-generation instruction-decode/operand stage: integer and vector register files, ID/EX pipeline register, per-register scoreboard.
- Takes pre-decoded fields from the existing decoder and delivers operands to EX over a valid/ready handshake.
- Unlike the previous stage, stalls on RAW/WAW hazards, bypasses same-cycle writeback, accepts back-pressure and supports flush.

Parameters:
REGI_BITS, 4, integer register address width (2**REGI_BITS regs)
VECT_BITS, 2, vector register address width
REGI_SIZE, 16, integer register width
VECT_SIZE, 8, elements per vector
ELEM_SIZE, 8, bits per element (>=8)
CNT_W, 2, scoreboard counter width (max 2**CNT_W-1 writers in flight per reg)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
i_src1, i_src2  in  REGI_BITS  integer source addresses
v_src1, v_src2  in  VECT_BITS  vector source addresses
i_dst  in  REGI_BITS  integer destination
v_dst  in  VECT_BITS  vector destination
use_i1, use_i2, use_v1, use_v2  in  1  source actually read
wr_i, wr_v  in  1  instruction writes int/vec dest
imm  in  8  immediate
ctrl_i  in  32  opaque control bundle (opcode, enables, flags), passed through
next_pc  in  REGI_SIZE  value returned when reading register 2**REGI_BITS-1
alu_flags_i  in  2  ALU flags, registered through
wb_i_we, wb_v_we  in  1  writeback enables
wb_i_dst  in  REGI_BITS;  wb_v_dst  in  VECT_BITS  writeback addresses
wb_i_data  in  REGI_SIZE;  wb_v_data  in  ELEM_SIZE*VECT_SIZE  writeback data
flush  in  1  kill instruction held in the output register and any incoming one
out_valid  out  1  EX payload valid
out_ready  in  1  EX accepts payload
i_op1, i_op2  out  REGI_SIZE;  v_op1, v_op2  out  ELEM_SIZE*VECT_SIZE  operands
v_imm  out  ELEM_SIZE*VECT_SIZE  imm zero-extended to ELEM_SIZE, replicated VECT_SIZE times
o_i_dst  out  REGI_BITS;  o_v_dst  out  VECT_BITS;  o_wr_i, o_wr_v  out  1;  ctrl_o  out  32;  alu_flags_o  out  2

Behaviour:
- Reset, asynchronous: all regfile entries, scoreboard counters, valid_q and all payload registers = 0. in_ready = 0 while rst is high.
- Register files:
  - Write at posedge when wb_*_we.
  - Reads are combinational and write-first: a read of the address being written this cycle returns wb data.
  - Integer address 2**REGI_BITS-1 always reads next_pc; writes to it are ignored.
- Scoreboard: one CNT_W counter per int reg and per vec reg.
  - issue = out_valid & out_ready. On issue, increment cnt[o_*_dst] if o_wr_*.
  - Writeback decrements cnt[wb_*_dst].
  - Increment and decrement of the same reg in the same cycle: unchanged.
  - Decrement at 0 is ignored (no underflow).
- Hazard, computed combinationally for the input instruction. Stall if any of:
  - a used source has cnt != 0, unless cnt == 1 and the same-cycle writeback targets it (bypass);
  - a used source equals the destination of a valid writer held in the output register;
  - the destination counter is at max (WAW overflow guard).
- in_ready = !rst & !hazard & (!valid_q | out_ready).
- capture = in_valid & in_ready & !flush. On capture the payload registers load (latency 1 cycle) and valid_q = 1.
- Else, if issue, valid_q = 0. Else, hold: payload is stable while out_valid & !out_ready.
- flush:
  - Has priority. valid_q <= 0 next cycle; out_valid = valid_q & !flush (flush-cycle payload never issues, no counter increment).
  - Incoming instruction is not captured; upstream must re-present it.
- Simultaneous issue and capture: pipelined, full throughput of 1 instr/cycle with no hazards.
- Widths: imm zero-extended to ELEM_SIZE before replication. Counters saturate by stall, never wrap.

Decomposition:
- Package id_pkg:
  - ctrl bundle typedef (32 bits);
  - scoreboard counter typedef;
  - constants PC_REG = 2**REGI_BITS-1 and CNT_MAX.
- Natural sub-module: sb_counter_bank, a parametrised array of up/down counters with inc/dec address ports and a per-entry busy/count read. Instantiated once for int, once for vec.
- The existing register-file and intToVect blocks are reused for storage and immediate broadcast.

Test Plan:
- Reset mid-stream, with out_valid=1 and cnt[3]=2 -> next cycle out_valid=0, all counters 0, all operands 0.
- Back-to-back independent instructions, out_ready=1, writers to r1 then r2 -> out_valid on consecutive cycles; cnt[1]=cnt[2]=1 after issue.
- RAW: issue a writer to r5, then a reader of r5 -> in_ready=0 until wb_i_we with wb_i_dst=5, wb_i_data=16'hBEEF; that same cycle in_ready=1 and the reader later shows i_op1=16'hBEEF.
- Back-pressure: out_ready=0 for 3 cycles -> payload and out_valid stable, in_ready=0, no counter change; out_ready=1 -> issue and capture in the same cycle.
- Flush with out_valid=1, out_ready=1 and a writer to v2 -> no issue, cnt_v[2] stays 0, out_valid=0 next cycle.
- Read r15 with next_pc=16'h0040 -> i_op1=16'h0040. imm=8'hA5 with ELEM_SIZE=8, VECT_SIZE=8 -> v_imm=64'hA5A5A5A5A5A5A5A5.
